sub_bytes_shift_rows_serial: RTL and testbench
==============================================

// Module: sub_bytes_shift_rows_serial
// PURPOSE
//   Area-optimised SubBytes+ShiftRows stage of the pipelined AES-128 round datapath; feeds mix_columns directly.
//   Reuses SBOX_LANES byte S-boxes over 16/SBOX_LANES cycles per 128-bit state instead of 16 parallel S-boxes.
//   Handshaked valid/ready on both sides; holds one state in flight plus its result.
// PARAMETERS
//   SBOX_LANES  4  S-box instances; legal values 1,2,4,8,16; NCYC = 16/SBOX_LANES substitution cycles
// PORTS
//   clk        in   1    rising-edge clock
//   rst_n      in   1    asynchronous active-low reset
//   in_valid   in   1    state_in valid
//   in_ready   out  1    stage can accept state_in this cycle
//   state_in   in   128  AES state, byte k = state_in[127-8k -: 8], column-major (row k%4, col k/4)
//   out_valid  out  1    state_out valid
//   out_ready  in   1    downstream (mix_columns stage) accepts state_out
//   state_out  out  128  ShiftRows(SubBytes(state_in)), same byte ordering
//   busy       out  1    high in SUB or HOLD
// BEHAVIOUR
//   FSM states IDLE, SUB, HOLD. Byte counter cnt, width clog2(NCYC) (min 1 bit).
//   Reset (rst_n low, async): state=IDLE, cnt=0, work reg=0, out_valid=0, state_out=0, busy=0.
//   in_ready = (IDLE) | (HOLD & out_ready); combinational, forced 0 while rst_n low.
//   IDLE: in_valid&in_ready -> capture state_in into work reg, cnt=0, go SUB.
//   SUB: each edge replaces bytes [cnt*SBOX_LANES .. cnt*SBOX_LANES+SBOX_LANES-1] of work reg with S(byte);
//     cnt increments; on cnt==NCYC-1 edge: cnt=0, go HOLD, out_valid<=1, state_out<=ShiftRows(final work reg).
//     in_valid ignored in SUB (in_ready=0); state_in not sampled.
//   Latency: out_valid first high NCYC cycles after the accepting edge (NCYC=4: accept E0, out_valid after E4).
//   HOLD: state_out/out_valid stable until out_ready. On out_valid&out_ready:
//     in_valid high -> capture new state, go SUB, out_valid<=0 (back-to-back, throughput 1 state / NCYC+1 cycles);
//     in_valid low -> go IDLE, out_valid<=0.
//   out_ready low in HOLD: stall indefinitely, no state change, state_out unchanged.
//   ShiftRows: out byte (r,c) = sub byte (r,(c+r)%4); row 0 unshifted, row r rotated left by r.
//   S-box per FIPS-197 table (S(00)=63, S(53)=ED); no inverse path in this block.
//   rst_n asserted mid-SUB or mid-HOLD: in-flight state discarded, all outputs to reset values immediately.
//   out_ready asserted while out_valid low: no effect.
// STRUCTURE
//   aes_pkg: S-box table/function, shift_rows function (128->128), FSM state encoding, AES_BYTES=16 constant.
//   Sub-module aes_sbox (8-bit combinational lookup), SBOX_LANES instances selected by cnt via byte mux.
//   Top: FSM + counter + 128-bit work reg + 128-bit output reg; shift_rows is pure wiring into output reg.
// TESTING
//   1. Reset then state_in=0, out_ready=1 -> state_out=636363..63 (128b), out_valid after 4 cycles, 1 cycle wide.
//   2. state_in=193DE3BEA0F4E22B9AC68D2AE9F84808 -> state_out=D4BF5D30E0B452AEB84111F11E2798E5 (FIPS-197 App.B
//      round 1); chained into mix_columns -> 046681E5E0CB199A48F8D37A2806264C.
//   3. out_ready low 10 cycles after out_valid -> state_out/out_valid held, in_ready=0 throughout; release -> one transfer.
//   4. in_valid held high, out_ready=1, 3 back-to-back states -> 3 outputs in order, spacing 5 cycles (NCYC=4).
//   5. rst_n pulsed low at SUB cnt==2 -> out_valid=0, state_out=0 at once; next input processed correctly.
//   6. SBOX_LANES=1 and 16 builds, vector of test 2 -> same result, latency 16 and 1 cycles respectively.

Source files
------------

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES constants, FSM encoding and pure-function helpers
// for the serial SubBytes+ShiftRows stage.
//   AES_BYTES   - bytes per 128-bit state
//   sr_state_e  - IDLE / SUB / HOLD encoding of the stage FSM
//   sbox()      - FIPS-197 forward S-box lookup
//   shift_rows()- 128->128 ShiftRows, byte k = s[127-8k -: 8], column-major
package aes_pkg;

  localparam int AES_BYTES = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SUB  = 2'd1,
    ST_HOLD = 2'd2
  } sr_state_e;

  // Entry 0 is the leftmost byte so the table reads like the FIPS-197 grid.
  localparam logic [0:255][7:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[b];
  endfunction

  // Packed byte view: byte k lives at element [15-k].
  // Row r of the output takes column (c+r)%4 of the input (rotate left by r).
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [AES_BYTES-1:0][7:0] b;
    logic [AES_BYTES-1:0][7:0] o;
    b = s;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[AES_BYTES-1-(4*c+r)] = b[AES_BYTES-1-(4*((c+r)%4)+r)];
    return o;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// aes_sbox: single-byte combinational forward S-box.
//   din  - input byte
//   dout - S(din)
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] din,
  output logic [7:0] dout
);

  assign dout = sbox(din);

endmodule

// File: rtl/sub_bytes_shift_rows_serial.sv
// sub_bytes_shift_rows_serial: area-reduced SubBytes+ShiftRows stage.
// SBOX_LANES S-boxes are time-shared across the 16 state bytes over
// NCYC = 16/SBOX_LANES cycles; the finished state is row-shifted into the
// output register and held until the downstream stage takes it.
//   clk, rst_n            - clock, async active-low reset
//   in_valid/in_ready     - input handshake, state_in column-major bytes
//   out_valid/out_ready   - output handshake, state_out = ShiftRows(SubBytes)
//   busy                  - a state is being substituted or held
module sub_bytes_shift_rows_serial
  import aes_pkg::*;
#(
  parameter int SBOX_LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out,
  output logic         busy
);

  localparam int NCYC = AES_BYTES / SBOX_LANES;
  localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCYC - 1);

  sr_state_e                  state, state_nxt;
  logic [CW-1:0]              cnt, cnt_nxt;
  logic [AES_BYTES-1:0][7:0]  work, work_nxt, sub;
  logic                       out_valid_nxt;
  logic [127:0]               state_out_nxt;

  logic [SBOX_LANES-1:0][3:0] sel;
  logic [SBOX_LANES-1:0][7:0] sb_in, sb_out;

  // Lane l handles byte cnt*SBOX_LANES + l of the current slice.
  for (genvar l = 0; l < SBOX_LANES; l++) begin : g_lane
    assign sel[l]   = 4'((32'(cnt) * SBOX_LANES) + l);
    assign sb_in[l] = work[4'(AES_BYTES-1) - sel[l]];
    aes_sbox u_sbox (.din(sb_in[l]), .dout(sb_out[l]));
  end

  // Gated by rst_n so the upstream never sees a ready during reset.
  assign in_ready = rst_n & ((state == ST_IDLE) | ((state == ST_HOLD) & out_ready));
  assign busy     = (state != ST_IDLE);

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    work_nxt      = work;
    out_valid_nxt = out_valid;
    state_out_nxt = state_out;
    sub           = work;
    for (int l = 0; l < SBOX_LANES; l++)
      sub[4'(AES_BYTES-1) - sel[l]] = sb_out[l];
    case (state)
      ST_IDLE: if (in_valid) begin
        work_nxt  = state_in;
        cnt_nxt   = '0;
        state_nxt = ST_SUB;
      end
      ST_SUB: begin
        work_nxt = sub;
        if (cnt == LAST) begin
          // Shift the freshly completed slice, not the stale work reg.
          cnt_nxt       = '0;
          state_nxt     = ST_HOLD;
          out_valid_nxt = 1'b1;
          state_out_nxt = shift_rows(sub);
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_HOLD: if (out_ready) begin
        out_valid_nxt = 1'b0;
        if (in_valid) begin
          work_nxt  = state_in;
          cnt_nxt   = '0;
          state_nxt = ST_SUB;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      work      <= '0;
      out_valid <= 1'b0;
      state_out <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      work      <= work_nxt;
      out_valid <= out_valid_nxt;
      state_out <= state_out_nxt;
    end
  end

endmodule

// File: tb/tb_sub_bytes_shift_rows_serial.sv
// Directed bench for sub_bytes_shift_rows_serial: main instance with 4 lanes
// plus 1-lane and 16-lane builds for latency scaling.
module tb_sub_bytes_shift_rows_serial;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         iv_aux = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] state_in = '0;

  logic         in_ready, out_valid, busy;
  logic [127:0] state_out;
  logic         rdy1, ov1, busy1, rdy16, ov16, busy16;
  logic [127:0] so1, so16;

  int total = 0;
  int bad   = 0;

  localparam logic [127:0] V_ZERO = 128'h0;
  localparam logic [127:0] E_ZERO = {16{8'h63}};
  localparam logic [127:0] V_FIPS = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] E_FIPS = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [127:0] E_MIX  = 128'h046681e5e0cb199a48f8d37a2806264c;
  localparam logic [127:0] V_SEQ  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] E_SEQ  = 128'h63fcac161bee28c3c4c193f54b8233ea;

  sub_bytes_shift_rows_serial #(.SBOX_LANES(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .state_in(state_in), .out_valid(out_valid), .out_ready(out_ready),
    .state_out(state_out), .busy(busy)
  );

  sub_bytes_shift_rows_serial #(.SBOX_LANES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_aux), .in_ready(rdy1),
    .state_in(state_in), .out_valid(ov1), .out_ready(out_ready),
    .state_out(so1), .busy(busy1)
  );

  sub_bytes_shift_rows_serial #(.SBOX_LANES(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_aux), .in_ready(rdy16),
    .state_in(state_in), .out_valid(ov16), .out_ready(out_ready),
    .state_out(so16), .busy(busy16)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [15:0][7:0] b, o;
    b = s;
    for (int c = 0; c < 4; c++) begin
      logic [7:0] a0, a1, a2, a3;
      a0 = b[15-4*c]; a1 = b[14-4*c]; a2 = b[13-4*c]; a3 = b[12-4*c];
      o[15-4*c] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
      o[14-4*c] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
      o[13-4*c] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
      o[12-4*c] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    end
    return o;
  endfunction

  // Accept one state from IDLE, then measure cycles to out_valid.
  task automatic run_one(input logic [127:0] v, input logic [127:0] exp, input int exp_lat,
                         input string tag);
    int lat;
    lat = 0;
    state_in = v;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      tick;
      if (out_valid) begin
        lat = n;
        break;
      end
    end
    chk({tag, "_lat"}, 128'(lat), 128'(exp_lat));
    chk(tag, state_out, exp);
  endtask

  initial begin
    logic [127:0] vec [3];
    logic [127:0] exv [3];
    int idx, outs, last, l1, l16;
    logic acc;

    // reset state
    #3;
    chk("rst_outs", {124'h0, in_ready, out_valid, busy, 1'b0}, 128'h0);
    chk("rst_data", state_out, 128'h0);
    #10 rst_n = 1'b1;
    tick;
    chk("idle_ready", {127'h0, in_ready}, 128'h1);

    // 1: all-zero state
    out_ready = 1'b1;
    run_one(V_ZERO, E_ZERO, 4, "zero");
    tick;
    chk("zero_pulse", {126'h0, out_valid, busy}, 128'h0);

    // 2: FIPS-197 round 1, chained into a MixColumns model
    run_one(V_FIPS, E_FIPS, 4, "fips");
    chk("fips_mix", mix_columns(state_out), E_MIX);
    tick;

    // 3: output stall
    out_ready = 1'b0;
    run_one(V_SEQ, E_SEQ, 4, "seq");
    for (int i = 0; i < 10; i++) begin
      tick;
      chk("stall_hs", {125'h0, out_valid, in_ready, busy}, 128'h5);
      chk("stall_data", state_out, E_SEQ);
    end
    out_ready = 1'b1;
    #1;
    chk("release_rdy", {127'h0, in_ready}, 128'h1);
    tick;
    chk("release_xfer", {126'h0, out_valid, busy}, 128'h0);
    tick;
    chk("release_once", {127'h0, out_valid}, 128'h0);

    // 4: back-to-back states
    vec[0] = V_ZERO; vec[1] = V_FIPS; vec[2] = V_SEQ;
    exv[0] = E_ZERO; exv[1] = E_FIPS; exv[2] = E_SEQ;
    idx = 0; outs = 0; last = 0;
    state_in = vec[0];
    in_valid = 1'b1;
    for (int cyc = 1; cyc <= 80; cyc++) begin
      acc = in_valid & in_ready;
      tick;
      if (acc) begin
        idx++;
        if (idx < 3) state_in = vec[idx];
        else in_valid = 1'b0;
      end
      if (out_valid) begin
        chk($sformatf("b2b_data%0d", outs), state_out, exv[outs]);
        if (outs > 0) chk($sformatf("b2b_gap%0d", outs), 128'(cyc - last), 128'd5);
        last = cyc;
        outs++;
        if (outs == 3) break;
      end
    end
    in_valid = 1'b0;
    chk("b2b_count", 128'(outs), 128'd3);
    tick;

    // 5: reset mid-SUB at cnt==2
    state_in = V_FIPS;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tick;
    tick;
    rst_n = 1'b0;
    #1;
    chk("midrst_outs", {125'h0, out_valid, busy, in_ready}, 128'h0);
    chk("midrst_data", state_out, 128'h0);
    #2 rst_n = 1'b1;
    tick;
    run_one(V_FIPS, E_FIPS, 4, "postrst");
    tick;

    // 6: 1-lane and 16-lane builds
    state_in = V_FIPS;
    iv_aux = 1'b1;
    tick;
    iv_aux = 1'b0;
    l1 = 0; l16 = 0;
    for (int n = 1; n <= 30; n++) begin
      tick;
      if (ov1 && l1 == 0) begin
        l1 = n;
        chk("l1_data", so1, E_FIPS);
      end
      if (ov16 && l16 == 0) begin
        l16 = n;
        chk("l16_data", so16, E_FIPS);
      end
      if (l1 != 0 && l16 != 0) break;
    end
    chk("l1_lat", 128'(l1), 128'd16);
    chk("l16_lat", 128'(l16), 128'd1);
    tick;
    chk("aux_idle", {124'h0, rdy1, rdy16, busy1, busy16}, 128'hc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
